// File: rtl/sap_control_sequencer.sv
// Control sequencer for the 8-bit SAP datapath: a one-hot T-state ring counter,
// opcode decode into the control word, latched ALU flags and HLT handling.
module sap_control_sequencer #(
  parameter int OPCODE_W = 4,
  parameter int TSTATES  = 6
) (
  input  logic                CLK,
  input  logic                CLR_n,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic [1:0]          Flags,
  output logic                Cp,
  output logic                Ep,
  output logic                Lm,
  output logic                CE,
  output logic                Li,
  output logic                Ei,
  output logic                La,
  output logic                Ea,
  output logic                Lb,
  output logic                Lo,
  output logic                Jp,
  output logic [1:0]          Operation,
  output logic                ALUOut,
  output logic                Hlt,
  output logic [5:0]          TState,
  output logic [1:0]          FlagReg
);

  // The ring counter is the FSM; its one-hot encoding is exported as TState.
  typedef enum logic [TSTATES-1:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  localparam logic [OPCODE_W-1:0] OP_LDA = 'h0;
  localparam logic [OPCODE_W-1:0] OP_ADD = 'h1;
  localparam logic [OPCODE_W-1:0] OP_SUB = 'h2;
  localparam logic [OPCODE_W-1:0] OP_INC = 'h3;
  localparam logic [OPCODE_W-1:0] OP_DCR = 'h4;
  localparam logic [OPCODE_W-1:0] OP_JMP = 'h5;
  localparam logic [OPCODE_W-1:0] OP_JZ  = 'h6;
  localparam logic [OPCODE_W-1:0] OP_JC  = 'h7;
  localparam logic [OPCODE_W-1:0] OP_OUT = 'he;
  localparam logic [OPCODE_W-1:0] OP_HLT = 'hf;

  tstate_e    state_q, state_d;
  logic       halted_q, halted_d;
  logic [1:0] flag_q, flag_d;
  logic       flag_load;

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q  <= T1;
      halted_q <= 1'b0;
      flag_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      flag_q   <= flag_d;
    end
  end

  assign TState  = state_q;
  assign FlagReg = flag_q;

  always_comb begin
    Cp        = 1'b0;
    Ep        = 1'b0;
    Lm        = 1'b0;
    CE        = 1'b0;
    Li        = 1'b0;
    Ei        = 1'b0;
    La        = 1'b0;
    Ea        = 1'b0;
    Lb        = 1'b0;
    Lo        = 1'b0;
    Jp        = 1'b0;
    Operation = 2'b00;
    ALUOut    = 1'b0;
    Hlt       = 1'b0;
    flag_load = 1'b0;
    state_d   = state_q;
    halted_d  = halted_q;
    flag_d    = flag_q;

    if (halted_q) begin
      // Counter frozen at T4; only the asynchronous clear leaves this state.
      Hlt = 1'b1;
    end else begin
      case (state_q)
        T1: begin
          Ep      = 1'b1;
          Lm      = 1'b1;
          state_d = T2;
        end
        T2: begin
          Cp      = 1'b1;
          state_d = T3;
        end
        T3: begin
          CE      = 1'b1;
          Li      = 1'b1;
          state_d = T4;
        end
        T4: begin
          state_d = T5;
          case (Opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              Ei = 1'b1;
              Lm = 1'b1;
            end
            OP_INC: begin
              ALUOut    = 1'b1;
              La        = 1'b1;
              Operation = 2'b10;
              flag_load = 1'b1;
            end
            OP_DCR: begin
              ALUOut    = 1'b1;
              La        = 1'b1;
              Operation = 2'b11;
              flag_load = 1'b1;
            end
            OP_JMP: begin
              Ei = 1'b1;
              Jp = 1'b1;
            end
            OP_JZ: begin
              Ei = flag_q[1];
              Jp = flag_q[1];
            end
            OP_JC: begin
              Ei = flag_q[0];
              Jp = flag_q[0];
            end
            OP_OUT: begin
              Ea = 1'b1;
              Lo = 1'b1;
            end
            OP_HLT: begin
              Hlt      = 1'b1;
              halted_d = 1'b1;
              state_d  = T4;
            end
            default: ;
          endcase
        end
        T5: begin
          state_d = T6;
          case (Opcode)
            OP_LDA: begin
              CE = 1'b1;
              La = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              CE = 1'b1;
              Lb = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          state_d = T1;
          if (Opcode == OP_ADD || Opcode == OP_SUB) begin
            ALUOut    = 1'b1;
            La        = 1'b1;
            Operation = (Opcode == OP_SUB) ? 2'b01 : 2'b00;
            flag_load = 1'b1;
          end
        end
        default: state_d = T1;
      endcase

      if (flag_load) flag_d = Flags;
    end
  end

endmodule
